// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between an I-side (port 0) and D-side (port 1) cache controller:
// round-robin grant, critical-word-first wrapping line fill, per-port beat steering, no-ack watchdog.
module mem_port_arbiter #(
    parameter int ADR_WIDTH         = 32,
    parameter int WORD_WIDTH        = 32,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WORD_NUM          = 2 ** WORD_OFFSET_WIDTH,
    parameter int TMO_WIDTH         = 7,
    parameter int TIMEOUT           = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_c0_2arb,
    input  logic [ADR_WIDTH-1:0]  adr_c0_2arb,
    output logic                  ack_arb2c0,
    output logic [WORD_WIDTH-1:0] dat_arb2c0,
    input  logic                  req_c1_2arb,
    input  logic [ADR_WIDTH-1:0]  adr_c1_2arb,
    output logic                  ack_arb2c1,
    output logic [WORD_WIDTH-1:0] dat_arb2c1,
    output logic                  req_arb2mem,
    output logic [ADR_WIDTH-1:0]  adr_arb2mem,
    input  logic                  ack_mem2arb,
    input  logic [WORD_WIDTH-1:0] dat_mem2arb,
    output logic [1:0]            grant,
    output logic                  err_timeout
);

    localparam int LINE_LSB = WORD_OFFSET_WIDTH + 2;
    localparam int LINE_W   = ADR_WIDTH - LINE_LSB;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = WORD_OFFSET_WIDTH'(WORD_NUM - 1);
    localparam logic [WORD_OFFSET_WIDTH-1:0] WORD_ONE  = WORD_OFFSET_WIDTH'(1);
    localparam logic [TMO_WIDTH-1:0]         TMO_LAST  = TMO_WIDTH'(TIMEOUT - 1);
    localparam logic [TMO_WIDTH-1:0]         TMO_ONE   = TMO_WIDTH'(1);

    logic [1:0]                   state_q, state_d;
    logic                         owner_q, owner_d;
    logic                         rr_q, rr_d;
    logic [WORD_OFFSET_WIDTH-1:0] word_q, word_d;
    logic [WORD_OFFSET_WIDTH-1:0] cnt_beat_q, cnt_beat_d;
    logic [TMO_WIDTH-1:0]         cnt_tmo_q, cnt_tmo_d;

    logic [1:0]                   pend_vec;
    logic [1:0]                   pend_clr;
    logic [LINE_W-1:0]            line_vec [2];
    logic [WORD_OFFSET_WIDTH-1:0] crit_vec [2];

    logic [1:0]                   req_vec;
    logic [ADR_WIDTH-1:0]         adr_vec [2];
    logic [1:0]                   ack_vec;
    logic [WORD_WIDTH-1:0]        dat_vec [2];

    logic                         serve;
    logic                         sel;
    logic                         err_w;

    // Byte-offset bits of the miss address carry no information for a word-wide fill.
    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^{adr_c0_2arb[1:0], adr_c1_2arb[1:0]};

    assign req_vec    = {req_c1_2arb, req_c0_2arb};
    assign adr_vec[0] = adr_c0_2arb;
    assign adr_vec[1] = adr_c1_2arb;
    assign serve      = (state_q == ST_SERVE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic IDX = (gi == 1);

            logic                         pend_q, pend_d;
            logic [LINE_W-1:0]            line_q, line_d;
            logic [WORD_OFFSET_WIDTH-1:0] crit_q, crit_d;
            logic                         capture;

            // A port already waiting or currently being filled cannot queue a second miss.
            assign capture = req_vec[gi] && !pend_q && !(serve && (owner_q == IDX));

            always_comb begin
                pend_d = pend_q;
                line_d = line_q;
                crit_d = crit_q;
                if (capture) begin
                    pend_d = 1'b1;
                    line_d = adr_vec[gi][ADR_WIDTH-1:LINE_LSB];
                    crit_d = adr_vec[gi][LINE_LSB-1:2];
                end else if (pend_clr[gi]) begin
                    pend_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pend_q <= 1'b0;
                    line_q <= '0;
                    crit_q <= '0;
                end else begin
                    pend_q <= pend_d;
                    line_q <= line_d;
                    crit_q <= crit_d;
                end
            end

            assign pend_vec[gi] = pend_q;
            assign line_vec[gi] = line_q;
            assign crit_vec[gi] = crit_q;

            assign ack_vec[gi] = ack_mem2arb && serve && (owner_q == IDX);
            assign dat_vec[gi] = ack_vec[gi] ? dat_mem2arb : '0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        word_d     = word_q;
        cnt_beat_d = cnt_beat_q;
        cnt_tmo_d  = cnt_tmo_q;
        pend_clr   = 2'b00;
        err_w      = 1'b0;
        sel        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_vec) begin
                    // rr_q only matters on contention; a lone requester always wins.
                    sel        = (&pend_vec) ? rr_q : pend_vec[1];
                    owner_d    = sel;
                    rr_d       = ~sel;
                    word_d     = crit_vec[sel];
                    cnt_beat_d = '0;
                    cnt_tmo_d  = '0;
                    pend_clr   = sel ? 2'b10 : 2'b01;
                    state_d    = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (ack_mem2arb) begin
                    word_d     = word_q + WORD_ONE;
                    cnt_beat_d = cnt_beat_q + WORD_ONE;
                    cnt_tmo_d  = '0;
                    if (cnt_beat_q == LAST_BEAT) begin
                        state_d = ST_RELEASE;
                    end
                end else if (cnt_tmo_q == TMO_LAST) begin
                    err_w   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_tmo_d = cnt_tmo_q + TMO_ONE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            word_q     <= '0;
            cnt_beat_q <= '0;
            cnt_tmo_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            word_q     <= word_d;
            cnt_beat_q <= cnt_beat_d;
            cnt_tmo_q  <= cnt_tmo_d;
        end
    end

    assign req_arb2mem = serve;
    assign grant       = serve ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign adr_arb2mem = serve ? {line_vec[owner_q], word_q, 2'b00} : '0;
    assign err_timeout = err_w;

    assign ack_arb2c0 = ack_vec[0];
    assign ack_arb2c1 = ack_vec[1];
    assign dat_arb2c0 = dat_vec[0];
    assign dat_arb2c1 = dat_vec[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected beats queued per port at request time,
// popped and compared as the arbiter steers memory beats back to each controller.
module tb_mem_port_arbiter;

    localparam int WN = 4;
    localparam logic [31:0] MASK = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_c0_2arb = 1'b0;
    logic        req_c1_2arb = 1'b0;
    logic [31:0] adr_c0_2arb = '0;
    logic [31:0] adr_c1_2arb = '0;
    logic        ack_arb2c0, ack_arb2c1;
    logic [31:0] dat_arb2c0, dat_arb2c1;
    logic        req_arb2mem;
    logic [31:0] adr_arb2mem;
    logic        ack_mem2arb = 1'b0;
    logic [31:0] dat_mem2arb = '0;
    logic [1:0]  grant;
    logic        err_timeout;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_mode = 0;   // 0: ack every cycle, 1: random acks, 2: never ack

    int         start_cyc[$];
    logic [1:0] start_port[$];
    int         start_gap[$];
    int         last_ack_cyc = -100;
    int         n_ack0 = 0;
    int         n_ack1 = 0;
    int         n_err = 0;
    int         err_cyc = 0;
    logic [1:0] prev_grant = 2'b00;
    logic       prev_err = 1'b0;
    logic [1:0] grant_after_err = 2'b11;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_c0_2arb (req_c0_2arb),
        .adr_c0_2arb (adr_c0_2arb),
        .ack_arb2c0  (ack_arb2c0),
        .dat_arb2c0  (dat_arb2c0),
        .req_c1_2arb (req_c1_2arb),
        .adr_c1_2arb (adr_c1_2arb),
        .ack_arb2c1  (ack_arb2c1),
        .dat_arb2c1  (dat_arb2c1),
        .req_arb2mem (req_arb2mem),
        .adr_arb2mem (adr_arb2mem),
        .ack_mem2arb (ack_mem2arb),
        .dat_mem2arb (dat_mem2arb),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: responds to the registered request just after each rising edge.
    always @(posedge clk) begin
        #1;
        ack_mem2arb = req_arb2mem && ((mem_mode == 0) || (mem_mode == 1 && $urandom_range(0, 1) == 1));
        dat_mem2arb = adr_arb2mem ^ MASK;
    end

    // Monitor: pops and compares every steered beat, logs fill starts and watchdog pulses.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            prev_grant = 2'b00;
            prev_err   = 1'b0;
        end else begin
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                start_cyc.push_back(cyc);
                start_port.push_back(grant);
                start_gap.push_back(cyc - last_ack_cyc);
                $display("fill start: grant=%b adr=0x%08h cycle=%0d", grant, adr_arb2mem, cyc);
            end
            if (ack_arb2c0 && ack_arb2c1) check("dual_ack", 32'd1, 32'd0);
            if (ack_arb2c0) begin
                n_ack0 = n_ack0 + 1;
                last_ack_cyc = cyc;
                if (q0.size() == 0) check("c0_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    check("c0_adr", adr_arb2mem, e.adr);
                    check("c0_dat", dat_arb2c0, e.dat);
                    check("c0_grant", 32'(grant), 32'h1);
                end
            end else if (dat_arb2c0 != 32'h0) check("c0_dat_idle", dat_arb2c0, 32'h0);
            if (ack_arb2c1) begin
                n_ack1 = n_ack1 + 1;
                last_ack_cyc = cyc;
                if (q1.size() == 0) check("c1_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("c1_adr", adr_arb2mem, e.adr);
                    check("c1_dat", dat_arb2c1, e.dat);
                    check("c1_grant", 32'(grant), 32'h2);
                end
            end else if (dat_arb2c1 != 32'h0) check("c1_dat_idle", dat_arb2c1, 32'h0);
            if (prev_err) grant_after_err = grant;
            if (err_timeout) begin
                n_err   = n_err + 1;
                err_cyc = cyc;
            end
            prev_err   = err_timeout;
            prev_grant = grant;
        end
    end

    task automatic push_fill(input int port, input logic [31:0] a);
        for (int k = 0; k < WN; k++) begin
            beat_t b;
            logic [1:0] w;
            w     = a[3:2] + 2'(k);
            b.adr = {a[31:4], w, 2'b00};
            b.dat = b.adr ^ MASK;
            if (port == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic pulse(input logic p0, input logic [31:0] a0, input logic p1, input logic [31:0] a1,
                         input int len, output int pc);
        @(negedge clk);
        pc = cyc;
        req_c0_2arb = p0;
        adr_c0_2arb = a0;
        req_c1_2arb = p1;
        adr_c1_2arb = a1;
        repeat (len) @(negedge clk);
        req_c0_2arb = 1'b0;
        req_c1_2arb = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || req_arb2mem) && n < budget) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        check({tag, "_drained"}, 32'(n < budget), 32'd1);
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"}, 32'(req_arb2mem), 32'd0);
        check({tag, "_adr"}, adr_arb2mem, 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_ack0"}, 32'(ack_arb2c0), 32'd0);
        check({tag, "_ack1"}, 32'(ack_arb2c1), 32'd0);
        check({tag, "_dat0"}, dat_arb2c0, 32'd0);
        check({tag, "_dat1"}, dat_arb2c1, 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int pc, base, acks, e0, n, target;

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous requests straight after reset: c0 wins, c1 follows after a release gap.
        push_fill(0, 32'h0000_1238);
        push_fill(1, 32'h0000_4404);
        base = start_cyc.size();
        pulse(1'b1, 32'h0000_1238, 1'b1, 32'h0000_4404, 1, pc);
        wait_drain("both", 60);
        check("both_nfills", 32'(start_cyc.size() - base), 32'd2);
        if (start_cyc.size() >= base + 2) begin
            check("both_first", 32'(start_port[base]), 32'h1);
            check("both_latency", 32'(start_cyc[base] - pc), 32'd2);
            check("both_second", 32'(start_port[base + 1]), 32'h2);
            check("both_gap", 32'(start_gap[base + 1]), 32'd3);
        end

        // Lone c0 request: critical word 0x1238, two-cycle latency; leaves the pointer favouring c1.
        push_fill(0, 32'h0000_1238);
        base = start_cyc.size();
        pulse(1'b1, 32'h0000_1238, 1'b0, 32'h0, 1, pc);
        wait_drain("solo", 40);
        check("solo_nfills", 32'(start_cyc.size() - base), 32'd1);
        if (start_cyc.size() >= base + 1) begin
            check("solo_port", 32'(start_port[base]), 32'h1);
            check("solo_latency", 32'(start_cyc[base] - pc), 32'd2);
        end

        // Contention again with random memory stalls: c1 goes first this time.
        mem_mode = 1;
        push_fill(0, 32'h0000_2004);
        push_fill(1, 32'h0000_300C);
        base = start_cyc.size();
        pulse(1'b1, 32'h0000_2004, 1'b1, 32'h0000_300C, 1, pc);
        wait_drain("rr", 200);
        check("rr_nfills", 32'(start_cyc.size() - base), 32'd2);
        if (start_cyc.size() >= base + 2) begin
            check("rr_first", 32'(start_port[base]), 32'h2);
            check("rr_second", 32'(start_port[base + 1]), 32'h1);
            check("rr_gap", 32'(start_gap[base + 1]), 32'd3);
        end
        mem_mode = 0;

        // c1 misses while c0 is being filled: it waits, then starts three cycles after c0's last beat.
        push_fill(0, 32'h0000_8008);
        base = start_cyc.size();
        pulse(1'b1, 32'h0000_8008, 1'b0, 32'h0, 1, pc);
        @(negedge clk);
        push_fill(1, 32'h0000_900C);
        pulse(1'b0, 32'h0, 1'b1, 32'h0000_900C, 1, pc);
        wait_drain("overlap", 60);
        check("overlap_nfills", 32'(start_cyc.size() - base), 32'd2);
        if (start_cyc.size() >= base + 2) begin
            check("overlap_first", 32'(start_port[base]), 32'h1);
            check("overlap_second", 32'(start_port[base + 1]), 32'h2);
            check("overlap_gap", 32'(start_gap[base + 1]), 32'd3);
        end

        // Duplicate c0 requests (while pending, then while owner) yield a single fill.
        push_fill(0, 32'h0000_A000);
        base = start_cyc.size();
        acks = n_ack0;
        pulse(1'b1, 32'h0000_A000, 1'b0, 32'h0, 2, pc);
        pulse(1'b1, 32'h0000_A000, 1'b0, 32'h0, 1, pc);
        wait_drain("dup", 60);
        check("dup_nfills", 32'(start_cyc.size() - base), 32'd1);
        check("dup_nbeats", 32'(n_ack0 - acks), 32'd4);

        // Memory never answers: watchdog fires in the 64th serve cycle and drops the grant.
        mem_mode = 2;
        base = start_cyc.size();
        acks = n_ack0 + n_ack1;
        e0 = n_err;
        pulse(1'b0, 32'h0, 1'b1, 32'h0000_B004, 1, pc);
        n = 0;
        while (n_err == e0 && n < 150) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        check("tmo_seen", 32'(n < 150), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("tmo_npulses", 32'(n_err - e0), 32'd1);
        check("tmo_acks", 32'(n_ack0 + n_ack1 - acks), 32'd0);
        check("tmo_grant_after", 32'(grant_after_err), 32'd0);
        if (start_cyc.size() >= base + 1) begin
            check("tmo_port", 32'(start_port[base]), 32'h2);
            check("tmo_cycle", 32'(err_cyc - start_cyc[base]), 32'd63);
        end
        mem_mode = 0;
        repeat (3) @(negedge clk);

        // Reset after two of four c0 beats, with c1 pending: everything is dropped.
        push_fill(0, 32'h0000_C00C);
        base = start_cyc.size();
        target = n_ack0 + 2;
        pulse(1'b1, 32'h0000_C00C, 1'b0, 32'h0, 1, pc);
        pulse(1'b0, 32'h0, 1'b1, 32'h0000_F000, 1, pc);
        n = 0;
        while (n_ack0 < target && n < 20) begin
            @(negedge clk);
            #2;
            n = n + 1;
        end
        check("rst_mid_reached", 32'(n < 20), 32'd1);
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        q0.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("rst_no_pending", 32'(start_cyc.size() - base), 32'd1);
        check("rst_idle_req", 32'(req_arb2mem), 32'd0);

        push_fill(0, 32'h0000_D000);
        push_fill(1, 32'h0000_E008);
        base = start_cyc.size();
        pulse(1'b1, 32'h0000_D000, 1'b1, 32'h0000_E008, 1, pc);
        wait_drain("post_rst", 60);
        check("post_rst_nfills", 32'(start_cyc.size() - base), 32'd2);
        if (start_cyc.size() >= base + 1) begin
            check("post_rst_first", 32'(start_port[base]), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
